// File: rtl/pulse_cmd_scheduler_pkg.sv
// Shared widths, FSM encoding and write-mask bit positions
// for the per-channel pulse command scheduler.
package pulse_cmd_scheduler_pkg;

  localparam int PHASE_W = 14;
  localparam int FREQ_W  = 24;
  localparam int TREF_W  = 24;
  localparam int ENV_W   = 24;
  localparam int DEPTH_D = 4;

  localparam int WM_PHASE = 0;
  localparam int WM_FREQ  = 1;
  localparam int WM_ENV   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIRE = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_cmd_scheduler_if.sv
// Processor-side command bus: valid/ready handshake
// carrying one timed pulse command.
interface pulse_cmd_scheduler_if
  import pulse_cmd_scheduler_pkg::*;
#(
  parameter int PHASE_WIDTH    = PHASE_W,
  parameter int FREQ_WIDTH     = FREQ_W,
  parameter int TREF_WIDTH     = TREF_W,
  parameter int ENV_WORD_WIDTH = ENV_W
);

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [TREF_WIDTH-1:0]     cmd_time;
  logic [PHASE_WIDTH-1:0]    cmd_phase;
  logic [FREQ_WIDTH-1:0]     cmd_freq;
  logic [ENV_WORD_WIDTH-1:0] cmd_env;
  logic [2:0]                cmd_wmask;

  modport master (
    output cmd_valid, cmd_time, cmd_phase,
    output cmd_freq, cmd_env, cmd_wmask,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_time, cmd_phase,
    input  cmd_freq, cmd_env, cmd_wmask,
    output cmd_ready
  );

endinterface

// File: rtl/pulse_cmd_scheduler_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO
// with full/empty flags; pushes are dropped while full.
module pulse_cmd_scheduler_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit tells full from empty when indices match
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pulse_cmd_scheduler.sv
// Timed sequencer: holds queued pulse commands until tref
// reaches their start time, then strobes them into the register.
module pulse_cmd_scheduler
  import pulse_cmd_scheduler_pkg::*;
#(
  parameter int PHASE_WIDTH    = PHASE_W,
  parameter int FREQ_WIDTH     = FREQ_W,
  parameter int TREF_WIDTH     = TREF_W,
  parameter int ENV_WORD_WIDTH = ENV_W,
  parameter int DEPTH          = DEPTH_D
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [TREF_WIDTH-1:0]     tref,
  pulse_cmd_scheduler_if.slave      cmd,
  input  logic                      err_clear,
  output logic [PHASE_WIDTH-1:0]    phase_offs_out,
  output logic [FREQ_WIDTH-1:0]     freq_out,
  output logic [ENV_WORD_WIDTH-1:0] env_word_out,
  output logic                      phase_write_en,
  output logic                      freq_write_en,
  output logic                      env_word_write_en,
  output logic                      cstrobe_out,
  output logic                      busy,
  output logic                      late_err
);

  localparam int FW = TREF_WIDTH + PHASE_WIDTH +
                      FREQ_WIDTH + ENV_WORD_WIDTH + 3;

  state_t state;
  state_t state_n;

  logic [FW-1:0]             wdata;
  logic [FW-1:0]             rdata;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      fire;
  logic                      late;
  logic [TREF_WIDTH-1:0]     h_time;
  logic [PHASE_WIDTH-1:0]    h_phase;
  logic [FREQ_WIDTH-1:0]     h_freq;
  logic [ENV_WORD_WIDTH-1:0] h_env;
  logic [2:0]                h_mask;
  logic [TREF_WIDTH-1:0]     dt;

  assign cmd.cmd_ready = !full && !rst;
  assign push = cmd.cmd_valid && cmd.cmd_ready;

  assign wdata = {cmd.cmd_time, cmd.cmd_phase,
                  cmd.cmd_freq, cmd.cmd_env,
                  cmd.cmd_wmask};
  assign {h_time, h_phase, h_freq, h_env, h_mask} = rdata;

  pulse_cmd_scheduler_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (fire),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Modular distance: negative (MSB set) means the start time has passed
  assign dt   = h_time - tref;
  assign late = (state == S_WAIT) && dt[TREF_WIDTH-1];
  assign fire = (state == S_WAIT) &&
                ((dt == '0) || dt[TREF_WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (!empty) state_n = S_WAIT;
      S_WAIT:  if (fire) state_n = S_FIRE;
      S_FIRE:  state_n = empty ? S_IDLE : S_WAIT;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_offs_out    <= '0;
      freq_out          <= '0;
      env_word_out      <= '0;
      phase_write_en    <= 1'b0;
      freq_write_en     <= 1'b0;
      env_word_write_en <= 1'b0;
      cstrobe_out       <= 1'b0;
    end else begin
      cstrobe_out       <= fire;
      phase_write_en    <= fire && h_mask[WM_PHASE];
      freq_write_en     <= fire && h_mask[WM_FREQ];
      env_word_write_en <= fire && h_mask[WM_ENV];
      if (fire) begin
        phase_offs_out <= h_phase;
        freq_out       <= h_freq;
        env_word_out   <= h_env;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            late_err <= 1'b0;
    else if (late)      late_err <= 1'b1;
    else if (err_clear) late_err <= 1'b0;
  end

  assign busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_pulse_cmd_scheduler.sv
// Directed bench for pulse_cmd_scheduler: on-time, late,
// full FIFO, wrap, mask/same-time and mid-wait reset.
module tb_pulse_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] tref = '0;
  logic        load = 1'b0;
  logic [23:0] load_val = '0;
  logic        err_clear = 1'b0;

  logic [13:0] phase_offs_out;
  logic [23:0] freq_out;
  logic [23:0] env_word_out;
  logic        phase_write_en;
  logic        freq_write_en;
  logic        env_word_write_en;
  logic        cstrobe_out;
  logic        busy;
  logic        late_err;

  int n_chk = 0;
  int n_fail = 0;
  int base;

  logic [23:0] fire_t [$];
  logic [2:0]  fire_m [$];
  logic        fire_l [$];

  pulse_cmd_scheduler_if cif ();

  pulse_cmd_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .tref              (tref),
    .cmd               (cif.slave),
    .err_clear         (err_clear),
    .phase_offs_out    (phase_offs_out),
    .freq_out          (freq_out),
    .env_word_out      (env_word_out),
    .phase_write_en    (phase_write_en),
    .freq_write_en     (freq_write_en),
    .env_word_write_en (env_word_write_en),
    .cstrobe_out       (cstrobe_out),
    .busy              (busy),
    .late_err          (late_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tref <= load ? load_val : tref + 24'd1;
  end

  always @(negedge clk) begin
    if (cstrobe_out) begin
      fire_t.push_back(tref);
      fire_m.push_back({env_word_write_en,
                        freq_write_en,
                        phase_write_en});
      fire_l.push_back(late_err);
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_tref(input logic [23:0] v);
    load = 1'b1;
    load_val = v;
    step();
    load = 1'b0;
  endtask

  task automatic push(input logic [23:0] t,
                      input logic [13:0] p,
                      input logic [23:0] f,
                      input logic [23:0] e,
                      input logic [2:0]  m);
    cif.cmd_valid = 1'b1;
    cif.cmd_time  = t;
    cif.cmd_phase = p;
    cif.cmd_freq  = f;
    cif.cmd_env   = e;
    cif.cmd_wmask = m;
    step();
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    for (int i = 0; i < 40 && !cstrobe_out; i++) step();
    chk(tag, 64'(cstrobe_out), 64'd1);
  endtask

  task automatic run_to(input logic [23:0] t);
    for (int i = 0; i < 200 && tref != t; i++) step();
    chk("run_to", 64'(tref), 64'(t));
  endtask

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_time  = '0;
    cif.cmd_phase = '0;
    cif.cmd_freq  = '0;
    cif.cmd_env   = '0;
    cif.cmd_wmask = '0;

    // reset state
    step();
    step();
    chk("rst_ready", 64'(cif.cmd_ready), 64'd0);
    chk("rst_cstrobe", 64'(cstrobe_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_late", 64'(late_err), 64'd0);
    chk("rst_phase", 64'(phase_offs_out), 64'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 64'(cif.cmd_ready), 64'd1);

    // 1: on-time fire
    set_tref(24'd100);
    push(24'd110, 14'h123, 24'hABCDEF, 24'h123456, 3'b111);
    wait_strobe("t1_strobe");
    chk("t1_tref", 64'(tref), 64'd111);
    chk("t1_pwe", 64'(phase_write_en), 64'd1);
    chk("t1_fwe", 64'(freq_write_en), 64'd1);
    chk("t1_ewe", 64'(env_word_write_en), 64'd1);
    chk("t1_phase", 64'(phase_offs_out), 64'h123);
    chk("t1_freq", 64'(freq_out), 64'hABCDEF);
    chk("t1_env", 64'(env_word_out), 64'h123456);
    chk("t1_late", 64'(late_err), 64'd0);
    step();
    chk("t1_cs_low", 64'(cstrobe_out), 64'd0);
    chk("t1_pwe_low", 64'(phase_write_en), 64'd0);
    chk("t1_phase_hold", 64'(phase_offs_out), 64'h123);
    chk("t1_idle", 64'(busy), 64'd0);

    // 2: late command
    set_tref(24'd500);
    push(24'd400, 14'h011, 24'h000222, 24'h000333, 3'b111);
    wait_strobe("t2_strobe");
    chk("t2_tref", 64'(tref), 64'd503);
    chk("t2_late", 64'(late_err), 64'd1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("t2_clear", 64'(late_err), 64'd0);

    // 3: FIFO full, order kept
    set_tref(24'd990);
    base = fire_t.size();
    for (int k = 0; k < 4; k++)
      push(24'(1000 + 10 * k), 14'(k), 24'(k), 24'(k), 3'b010);
    chk("t3_full", 64'(cif.cmd_ready), 64'd0);
    cif.cmd_valid = 1'b1;
    cif.cmd_time  = 24'd1040;
    for (int i = 0; i < 50 && !cif.cmd_ready; i++) step();
    chk("t3_5th_tref", 64'(tref), 64'd1001);
    step();
    cif.cmd_valid = 1'b0;
    run_to(24'd1046);
    chk("t3_nfire", 64'(fire_t.size() - base), 64'd5);
    if (fire_t.size() - base == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t3_time", 64'(fire_t[base + k]),
            64'(1001 + 10 * k));
        chk("t3_mask", 64'(fire_m[base + k]), 64'b010);
      end
    end
    chk("t3_late", 64'(late_err), 64'd0);

    // 4: timebase wrap
    set_tref(24'hFFFFFB);
    base = fire_t.size();
    push(24'd3, 14'h001, 24'h1, 24'h1, 3'b111);
    run_to(24'd8);
    chk("t4_nfire", 64'(fire_t.size() - base), 64'd1);
    if (fire_t.size() > base) begin
      chk("t4_time", 64'(fire_t[base]), 64'd4);
      chk("t4_late", 64'(fire_l[base]), 64'd0);
    end

    // 5: masks and same start time
    set_tref(24'd195);
    base = fire_t.size();
    push(24'd200, 14'h155, 24'h5, 24'h5, 3'b001);
    push(24'd200, 14'h2AA, 24'h6, 24'h6, 3'b100);
    run_to(24'd206);
    chk("t5_nfire", 64'(fire_t.size() - base), 64'd2);
    if (fire_t.size() - base == 2) begin
      chk("t5_t0", 64'(fire_t[base]), 64'd201);
      chk("t5_m0", 64'(fire_m[base]), 64'b001);
      chk("t5_l0", 64'(fire_l[base]), 64'd0);
      chk("t5_t1", 64'(fire_t[base + 1]), 64'd203);
      chk("t5_m1", 64'(fire_m[base + 1]), 64'b100);
      chk("t5_l1", 64'(fire_l[base + 1]), 64'd1);
    end
    chk("t5_phase", 64'(phase_offs_out), 64'h2AA);
    chk("t5_late", 64'(late_err), 64'd1);

    // 6: reset while waiting with 3 queued
    set_tref(24'd3000);
    push(24'd3010, 14'h7, 24'h7, 24'h7, 3'b111);
    push(24'd3020, 14'h8, 24'h8, 24'h8, 3'b111);
    push(24'd3030, 14'h9, 24'h9, 24'h9, 3'b111);
    step();
    step();
    chk("t6_busy_pre", 64'(busy), 64'd1);
    base = fire_t.size();
    rst = 1'b1;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_ready", 64'(cif.cmd_ready), 64'd0);
    chk("t6_phase", 64'(phase_offs_out), 64'd0);
    chk("t6_late", 64'(late_err), 64'd0);
    chk("t6_cs", 64'(cstrobe_out), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("t6_busy_post", 64'(busy), 64'd0);
    chk("t6_ready_post", 64'(cif.cmd_ready), 64'd1);
    run_to(24'd3040);
    chk("t6_nofire", 64'(fire_t.size() - base), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
